// File: rtl/color_mapper_fx.sv
// Pixel colour mapper: prioritised sprite layers over sky/ground bands and a gradient,
// with a frame-timed day/night fade of the bands and a post-hit blink of the avatar layer.
module color_mapper_fx #(
  parameter int COLOR_W         = 8,
  parameter int NUM_LAYERS      = 4,
  parameter int FADE_STEPS      = 16,
  parameter int FRAMES_PER_STEP = 4,
  parameter int BLINK_FRAMES    = 8,
  parameter int HIT_BLINKS      = 3
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             frame_start,
  input  logic                             pix_valid,
  input  logic [9:0]                       DrawX,
  input  logic [9:0]                       DrawY,
  input  logic [9:0]                       sky,
  input  logic [9:0]                       ground,
  input  logic [NUM_LAYERS-1:0]            layer_hit,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]  layer_rgb,
  input  logic                             night_req,
  input  logic                             avatar_hit,
  output logic                             out_valid,
  output logic [COLOR_W-1:0]               VGA_R,
  output logic [COLOR_W-1:0]               VGA_G,
  output logic [COLOR_W-1:0]               VGA_B,
  output logic                             fade_busy
);
  // state    | meaning
  // DAY      | level 0, waiting for night_req
  // TO_NIGHT | level rising one step every FRAMES_PER_STEP frames
  // NIGHT    | level FADE_STEPS, waiting for night_req to drop
  // TO_DAY   | level falling one step every FRAMES_PER_STEP frames
  localparam int LW  = $clog2(FADE_STEPS);
  localparam int LVW = LW + 1;
  localparam int IW  = COLOR_W + LW + 1;
  localparam int PW  = 3 * COLOR_W;
  localparam int CW  = $clog2(FRAMES_PER_STEP + 1);
  localparam int BW  = $clog2(BLINK_FRAMES + 1);
  localparam int HW  = $clog2(2 * HIT_BLINKS + 1);

  typedef enum logic [1:0] {DAY, TO_NIGHT, NIGHT, TO_DAY} fade_e;
  typedef enum logic [1:0] {CL_LAYER, CL_SKY, CL_GND, CL_GRAD} cls_e;

  function automatic logic [COLOR_W-1:0] map8(input logic [7:0] c8);
    logic [COLOR_W+7:0] t;
    t = {c8, {COLOR_W{1'b0}}};
    return COLOR_W'(t >> 8);
  endfunction

  function automatic logic [COLOR_W-1:0] lerp(input logic [COLOR_W-1:0] d,
                                               input logic [COLOR_W-1:0] n,
                                               input logic [LVW-1:0] l);
    logic [IW-1:0] acc;
    acc = IW'(d) * (IW'(FADE_STEPS) - IW'(l)) + IW'(n) * IW'(l);
    return COLOR_W'(acc >> LW);
  endfunction

  fade_e           st_q, st_d;
  logic [LVW-1:0]  lvl_q, lvl_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            step_up, step_dn;

  // The frame that starts a fade counts as its first frame, so a full fade
  // takes FADE_STEPS*FRAMES_PER_STEP frame_starts; a reversal restarts the count.
  always_comb begin
    st_d    = st_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (frame_start) begin
      unique case (st_q)
        DAY:      if (night_req) begin st_d = TO_NIGHT; step_up = 1'b1; end
        NIGHT:    if (!night_req) begin st_d = TO_DAY; step_dn = 1'b1; end
        TO_NIGHT: if (!night_req) begin st_d = TO_DAY; cnt_d = '0; end
                  else step_up = 1'b1;
        TO_DAY:   if (night_req) begin st_d = TO_NIGHT; cnt_d = '0; end
                  else step_dn = 1'b1;
        default:  st_d = DAY;
      endcase
    end
    if (step_up) begin
      if (lvl_q == LVW'(FADE_STEPS)) begin
        st_d  = NIGHT;
        cnt_d = '0;
      end else if (cnt_q == CW'(FRAMES_PER_STEP - 1)) begin
        cnt_d = '0;
        lvl_d = lvl_q + LVW'(1);
        if (lvl_q + LVW'(1) == LVW'(FADE_STEPS)) st_d = NIGHT;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (step_dn) begin
      if (lvl_q == '0) begin
        st_d  = DAY;
        cnt_d = '0;
      end else if (cnt_q == CW'(FRAMES_PER_STEP - 1)) begin
        cnt_d = '0;
        lvl_d = lvl_q - LVW'(1);
        if (lvl_q == LVW'(1)) st_d = DAY;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q  <= DAY;
      lvl_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign fade_busy = (st_q == TO_NIGHT) || (st_q == TO_DAY);

  // Blink phases count down; even non-zero phases hide the avatar, 0 is idle.
  logic [HW-1:0] ph_q, ph_d;
  logic [BW-1:0] bf_q, bf_d;
  logic          blink_off;

  always_comb begin
    ph_d = ph_q;
    bf_d = bf_q;
    if (avatar_hit) begin
      ph_d = HW'(2 * HIT_BLINKS);
      bf_d = '0;
    end else if (frame_start && ph_q != '0) begin
      if (bf_q == BW'(BLINK_FRAMES - 1)) begin
        bf_d = '0;
        ph_d = ph_q - HW'(1);
      end else begin
        bf_d = bf_q + BW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ph_q <= '0;
      bf_q <= '0;
    end else begin
      ph_q <= ph_d;
      bf_q <= bf_d;
    end
  end

  assign blink_off = (ph_q != '0) && !ph_q[0];

  logic [NUM_LAYERS-1:0] hit_m;
  logic [PW-1:0]         lay_c;
  cls_e                  cls_c;
  logic                  unused_drawx_lsb;

  assign unused_drawx_lsb = ^DrawX[2:0];

  always_comb begin
    hit_m    = layer_hit;
    hit_m[0] = layer_hit[0] & ~blink_off;
    lay_c    = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit_m[i]) lay_c = layer_rgb[i*PW +: PW];
    end
    if (|hit_m)             cls_c = CL_LAYER;
    else if (DrawY <= sky)    cls_c = CL_SKY;
    else if (DrawY >= ground) cls_c = CL_GND;
    else                      cls_c = CL_GRAD;
  end

  logic           s1_vld_q;
  cls_e           s1_cls_q;
  logic [PW-1:0]  s1_rgb_q;
  logic [6:0]     s1_xg_q;
  logic [LVW-1:0] s1_lvl_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_vld_q <= 1'b0;
      s1_cls_q <= CL_LAYER;
      s1_rgb_q <= '0;
      s1_xg_q  <= '0;
      s1_lvl_q <= '0;
    end else begin
      s1_vld_q <= pix_valid;
      s1_cls_q <= cls_c;
      s1_rgb_q <= lay_c;
      s1_xg_q  <= DrawX[9:3];
      s1_lvl_q <= lvl_q;
    end
  end

  logic [COLOR_W-1:0] r_c, g_c, b_c;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic               vld_q;

  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    unique case (s1_cls_q)
      CL_LAYER: {r_c, g_c, b_c} = s1_rgb_q;
      CL_SKY: begin
        r_c = lerp(map8(8'h00), map8(8'h00), s1_lvl_q);
        g_c = lerp(map8(8'hFF), map8(8'h10), s1_lvl_q);
        b_c = lerp(map8(8'hFF), map8(8'h40), s1_lvl_q);
      end
      CL_GND: begin
        r_c = lerp(map8(8'hFF), map8(8'h7F), s1_lvl_q);
        g_c = lerp(map8(8'hCC), map8(8'h66), s1_lvl_q);
        b_c = lerp(map8(8'h66), map8(8'h33), s1_lvl_q);
      end
      default: begin
        r_c = map8(8'h3F);
        g_c = map8(8'h00);
        b_c = map8(8'h7F - {1'b0, s1_xg_q});
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_q <= 1'b0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        r_q <= r_c;
        g_q <= g_c;
        b_q <= b_c;
      end
    end
  end

  assign out_valid = vld_q;
  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;

endmodule

// File: tb/tb_color_mapper_fx.sv
// Self-checking bench for color_mapper_fx: expected pixel colours are queued at drive
// time and compared when out_valid appears; fade/blink/reset checks are inline.
module tb_color_mapper_fx;
  logic        Clk = 1'b0;
  logic        Reset_n, frame_start, pix_valid, night_req, avatar_hit;
  logic [9:0]  DrawX, DrawY, sky, ground;
  logic [3:0]  layer_hit;
  logic [23:0] lr [4];
  logic [95:0] layer_rgb;
  logic        out_valid, fade_busy;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  int          vectors = 0;
  int          miscompares = 0;
  int          left;
  logic [23:0] sb [$];
  logic [23:0] mon_exp;

  localparam logic [9:0] Y_SKY = 10'd100;
  localparam logic [9:0] Y_MID = 10'd200;
  localparam logic [9:0] Y_GND = 10'd400;

  always #5 Clk = ~Clk;

  assign layer_rgb = {lr[3], lr[2], lr[1], lr[0]};

  color_mapper_fx dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .sky(sky), .ground(ground),
    .layer_hit(layer_hit), .layer_rgb(layer_rgb), .night_req(night_req),
    .avatar_hit(avatar_hit), .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .fade_busy(fade_busy)
  );

  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && out_valid === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL pixel_spurious: out_valid with %02h%02h%02h, required no output", VGA_R, VGA_G, VGA_B);
      end else begin
        mon_exp = sb.pop_front();
        if ({VGA_R, VGA_G, VGA_B} !== mon_exp) begin
          miscompares++;
          $display("FAIL pixel: got %02h%02h%02h, required %06h at %0t", VGA_R, VGA_G, VGA_B, mon_exp, $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic hit_pulse(input bit with_frame);
    avatar_hit  = 1'b1;
    frame_start = with_frame;
    tick();
    avatar_hit  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [3:0] hit,
                     input logic [23:0] exp);
    DrawX     = x;
    DrawY     = y;
    layer_hit = hit;
    pix_valid = 1'b1;
    sb.push_back(exp);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic drain(output int pending);
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    pending = sb.size();
    sb.delete();
  endtask

  function automatic bit hidden(input int k);
    return (k < 48) && ((k / 8) % 2 == 0);
  endfunction

  task automatic test_reset();
    Reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; night_req = 1'b0;
    avatar_hit = 1'b0; DrawX = '0; DrawY = '0; layer_hit = '0;
    sky = Y_SKY; ground = Y_GND;
    for (int i = 0; i < 4; i++) lr[i] = '0;
    repeat (3) @(posedge Clk);
    #1;
    vectors++;
    if ({out_valid, fade_busy, VGA_R, VGA_G, VGA_B} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %07h, required 0", {out_valid, fade_busy, VGA_R, VGA_G, VGA_B});
    end
    Reset_n = 1'b1;
    tick();
    lr[0] = 24'hFFFFFF;
    pix(10'd0, Y_MID, 4'b0001, 24'hFFFFFF);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_s1: out_valid %b one cycle after pixel, required 0", out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || {VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
      miscompares++;
      $display("FAIL latency_s2: got valid %b colour %02h%02h%02h, required 1 FFFFFF", out_valid, VGA_R, VGA_G, VGA_B);
    end
    drain(left);
    vectors++;
    if (left != 0) begin miscompares++; $display("FAIL drain_reset: %0d pending, required 0", left); end
  endtask

  task automatic test_back_to_back();
    lr[1] = 24'h112233; lr[2] = 24'h445566; lr[3] = 24'hABCDEF;
    pix(10'd0, Y_MID, 4'b0110, 24'h112233);
    pix(10'd0, Y_MID, 4'b1000, 24'hABCDEF);
    pix(10'd0, Y_SKY, 4'b0000, 24'h00FFFF);
    pix(10'd0, 10'd50, 4'b0000, 24'h00FFFF);
    pix(10'd0, Y_GND, 4'b0000, 24'hFFCC66);
    pix(10'd0, 10'd1023, 4'b0000, 24'hFFCC66);
    pix(10'd0, Y_SKY, 4'b0001, 24'hFFFFFF);
    pix(10'h080, Y_MID, 4'b0000, 24'h3F006F);
    pix(10'h000, Y_MID, 4'b0000, 24'h3F007F);
    pix(10'h3FF, Y_MID, 4'b0000, 24'h3F0000);
    pix(10'h007, 10'd101, 4'b0000, 24'h3F007F);
    pix(10'h008, 10'd399, 4'b0000, 24'h3F007E);
    drain(left);
    vectors++;
    if (left != 0) begin miscompares++; $display("FAIL drain_b2b: %0d pending, required 0", left); end
    sky = 10'd300; ground = 10'd200;
    pix(10'd0, 10'd250, 4'b0000, 24'h00FFFF);
    pix(10'd0, 10'd200, 4'b0000, 24'h00FFFF);
    pix(10'd0, 10'd301, 4'b0000, 24'hFFCC66);
    drain(left);
    vectors++;
    if (left != 0) begin miscompares++; $display("FAIL drain_overlap: %0d pending, required 0", left); end
    sky = Y_SKY; ground = Y_GND;
  endtask

  task automatic test_fade();
    night_req = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      frame();
      vectors++;
      if (fade_busy !== (k < 64)) begin
        miscompares++;
        $display("FAIL fade_busy_night: after %0d frames got %b, required %b", k, fade_busy, k < 64);
      end
      if (k == 8) begin
        pix(10'd0, Y_SKY, 4'b0000, 24'h00E1E7);
        pix(10'd0, Y_GND, 4'b0000, 24'hEFBF5F);
      end
    end
    pix(10'd0, Y_SKY, 4'b0000, 24'h001040);
    pix(10'd0, Y_GND, 4'b0000, 24'h7F6633);
    pix(10'd0, Y_MID, 4'b0000, 24'h3F007F);
    frame();
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fade_hold_night: got busy %b, required 0", fade_busy);
    end
    pix(10'd0, Y_SKY, 4'b0000, 24'h001040);
    drain(left);
    vectors++;
    if (left != 0) begin miscompares++; $display("FAIL drain_fade: %0d pending, required 0", left); end
  endtask

  task automatic test_reverse();
    night_req = 1'b0;
    repeat (64) frame();
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fade_back_day: got busy %b, required 0", fade_busy);
    end
    pix(10'd0, Y_SKY, 4'b0000, 24'h00FFFF);
    night_req = 1'b1;
    repeat (20) frame();
    pix(10'd0, Y_SKY, 4'b0000, 24'h00B4C3);
    night_req = 1'b0;
    frame();
    vectors++;
    if (fade_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reverse_busy: got %b, required 1", fade_busy);
    end
    pix(10'd0, Y_SKY, 4'b0000, 24'h00B4C3);
    for (int k = 1; k <= 20; k++) begin
      frame();
      vectors++;
      if (fade_busy !== (k < 20)) begin
        miscompares++;
        $display("FAIL reverse_busy_step: after %0d frames got %b, required %b", k, fade_busy, k < 20);
      end
      if (k == 4) pix(10'd0, Y_SKY, 4'b0000, 24'h00C3CF);
    end
    pix(10'd0, Y_SKY, 4'b0000, 24'h00FFFF);
    repeat (3) frame();
    vectors++;
    if (fade_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reverse_underflow: got busy %b, required 0", fade_busy);
    end
    pix(10'd0, Y_SKY, 4'b0000, 24'h00FFFF);
    drain(left);
    vectors++;
    if (left != 0) begin miscompares++; $display("FAIL drain_reverse: %0d pending, required 0", left); end
  endtask

  task automatic test_blink();
    lr[0] = 24'hFFFFFF; lr[1] = 24'h112233;
    hit_pulse(1'b0);
    pix(10'd0, Y_MID, 4'b0011, 24'h112233);
    for (int k = 1; k <= 50; k++) begin
      frame();
      pix(10'd0, Y_MID, 4'b0011, hidden(k) ? 24'h112233 : 24'hFFFFFF);
    end
    drain(left);
    vectors++;
    if (left != 0) begin miscompares++; $display("FAIL drain_blink: %0d pending, required 0", left); end
  endtask

  task automatic test_restart();
    hit_pulse(1'b0);
    for (int k = 1; k <= 20; k++) begin
      frame();
      pix(10'd0, Y_MID, 4'b0011, hidden(k) ? 24'h112233 : 24'hFFFFFF);
    end
    hit_pulse(1'b1);
    pix(10'd0, Y_MID, 4'b0011, 24'h112233);
    for (int j = 1; j <= 9; j++) begin
      frame();
      pix(10'd0, Y_MID, 4'b0011, hidden(j) ? 24'h112233 : 24'hFFFFFF);
    end
    drain(left);
    vectors++;
    if (left != 0) begin miscompares++; $display("FAIL drain_restart: %0d pending, required 0", left); end
  endtask

  task automatic test_reset_mid();
    hit_pulse(1'b0);
    frame();
    frame();
    night_req = 1'b1;
    frame();
    vectors++;
    if (fade_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_busy: got %b, required 1", fade_busy);
    end
    pix(10'd0, Y_MID, 4'b0011, 24'h112233);
    Reset_n = 1'b0;
    sb.delete();
    #2;
    vectors++;
    if ({out_valid, fade_busy, VGA_R, VGA_G, VGA_B} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %07h, required 0", {out_valid, fade_busy, VGA_R, VGA_G, VGA_B});
    end
    tick();
    Reset_n = 1'b1;
    night_req = 1'b0;
    tick();
    pix(10'd0, Y_MID, 4'b0011, 24'hFFFFFF);
    pix(10'd0, Y_SKY, 4'b0000, 24'h00FFFF);
    drain(left);
    vectors++;
    if (left != 0) begin miscompares++; $display("FAIL drain_reset_mid: %0d pending, required 0", left); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fade();
    test_reverse();
    test_blink();
    test_restart();
    test_reset_mid();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
